// File: rtl/dmc_bank_responder.sv
// -----------------------------------------------------------------------------
// dmc_bank_responder
//
// Memory-side responder for the data memory controller. Two banks (A and B)
// of 2^ADDR_W x DATA_W words each serve controller requests. Requests use a
// valid/ready channel. Read responses come back on a fixed-latency channel
// with no backpressure.
//
// After reset the block walks every address and writes zero into both banks
// (INIT). Only then does it start accepting requests (SERVE). This gives
// deterministic power-up contents without resetting the arrays themselves.
//
// Optional feature macro: PARITY_EN
//   When defined, each word stores an even-parity bit. On a write with
//   err_inject_i=1 that bit is stored inverted. Every read checks it.
//   When undefined, no parity is stored and the parity ports are absent.
//
// Parameters
//   ADDR_W  address width per bank (depth = 2^ADDR_W), must be >= 2
//   DATA_W  data word width
//   RD_LAT  read latency in clock edges, legal 1..4
//
// Ports
//   clk_i             clock, everything on posedge
//   rst_i             synchronous reset, active-high
//   req_valid_i       request present
//   req_ready_o       request can be accepted (high only in SERVE)
//   req_bank_i        0 = bank A, 1 = bank B
//   req_we_i          1 = write, 0 = read
//   req_addr_i        word address
//   req_wdata_i       write data
//   rsp_valid_o       one-cycle pulse per returned read
//   rsp_bank_o        bank of the returned read
//   rsp_data_o        read data, holds last value while rsp_valid_o=0
//   init_busy_o       high while the banks are being cleared
//   err_inject_i      (PARITY_EN) store inverted parity on this write
//   rsp_parity_err_o  (PARITY_EN) parity mismatch on the returned read
// -----------------------------------------------------------------------------
module dmc_bank_responder #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_bank_i,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
`ifdef PARITY_EN
  input  logic              err_inject_i,
  output logic              rsp_parity_err_o,
`endif
  output logic              rsp_valid_o,
  output logic              rsp_bank_o,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              init_busy_o
);

  localparam int DEPTH = 1 << ADDR_W;
`ifdef PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_SERVE = 1'b1
  } state_e;

  // Even-parity bit of a data word: the word plus this bit has an even number of ones.
  function automatic logic even_par(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

  // ---------------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
  logic              req_ready_q, req_ready_d;
  logic              init_busy_q, init_busy_d;
  logic              init_we_s;

  // ---------------------------------------------------------------------------
  // Storage and access path
  // ---------------------------------------------------------------------------
  logic [MEM_W-1:0]  mem_a_q [DEPTH];
  logic [MEM_W-1:0]  mem_b_q [DEPTH];

  logic              acc_s;
  logic              rd_fire_s;
  logic              wr_a_s;
  logic              wr_b_s;
  logic [ADDR_W-1:0] wr_addr_s;
  logic [MEM_W-1:0]  wr_word_s;
  logic [MEM_W-1:0]  rd_word_s;
  logic              rd_perr_s;

  // ---------------------------------------------------------------------------
  // Read pipeline; the last stage drives the response outputs directly
  // ---------------------------------------------------------------------------
  logic              pv_q [RD_LAT];
  logic              pb_q [RD_LAT];
  logic [DATA_W-1:0] pd_q [RD_LAT];
  logic              pe_q [RD_LAT];

  // Reset is gated in here so that no request can be committed on a reset edge.
  assign acc_s     = req_valid_i & req_ready_q & ~rst_i;
  assign rd_fire_s = acc_s & ~req_we_i;
  assign rd_word_s = req_bank_i ? mem_b_q[req_addr_i] : mem_a_q[req_addr_i];

`ifdef PARITY_EN
  assign rd_perr_s = even_par(rd_word_s[DATA_W-1:0]) ^ rd_word_s[DATA_W];
`else
  assign rd_perr_s = 1'b0;
`endif

  // FSM state register and registered handshake/status outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      req_ready_q <= 1'b0;
      init_busy_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      req_ready_q <= req_ready_d;
      init_busy_q <= init_busy_d;
    end
  end

  // FSM next state: clear one address per cycle, then serve until reset.
  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    req_ready_d = req_ready_q;
    init_busy_d = init_busy_q;
    init_we_s   = 1'b0;
    case (state_q)
      ST_INIT: begin
        init_we_s  = 1'b1;
        init_cnt_d = init_cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        if (init_cnt_q == {ADDR_W{1'b1}}) begin
          // Last address is cleared on this edge. Ready rises and busy falls together.
          state_d     = ST_SERVE;
          req_ready_d = 1'b1;
          init_busy_d = 1'b0;
        end else begin
          state_d     = ST_INIT;
          req_ready_d = 1'b0;
          init_busy_d = 1'b1;
        end
      end
      ST_SERVE: begin
        state_d     = ST_SERVE;
        req_ready_d = 1'b1;
        init_busy_d = 1'b0;
      end
      default: begin
        state_d     = ST_INIT;
        init_cnt_d  = '0;
        req_ready_d = 1'b0;
        init_busy_d = 1'b1;
      end
    endcase
  end

  // Write port selection: INIT clears both banks, SERVE writes the addressed bank.
  always_comb begin
    wr_a_s    = 1'b0;
    wr_b_s    = 1'b0;
    wr_addr_s = req_addr_i;
`ifdef PARITY_EN
    wr_word_s = {even_par(req_wdata_i) ^ err_inject_i, req_wdata_i};
`else
    wr_word_s = req_wdata_i;
`endif
    if (rst_i) begin
      wr_a_s = 1'b0;
      wr_b_s = 1'b0;
    end else if (init_we_s) begin
      // Zero data has zero parity, so an all-zero word is self-consistent.
      wr_a_s    = 1'b1;
      wr_b_s    = 1'b1;
      wr_addr_s = init_cnt_q;
      wr_word_s = '0;
    end else if (acc_s && req_we_i) begin
      wr_a_s = ~req_bank_i;
      wr_b_s = req_bank_i;
    end else begin
      wr_a_s = 1'b0;
      wr_b_s = 1'b0;
    end
  end

  // Bank A storage (contents are not reset; INIT clears them)
  always_ff @(posedge clk_i) begin
    if (wr_a_s) begin
      mem_a_q[wr_addr_s] <= wr_word_s;
    end
  end

  // Bank B storage (contents are not reset; INIT clears them)
  always_ff @(posedge clk_i) begin
    if (wr_b_s) begin
      mem_b_q[wr_addr_s] <= wr_word_s;
    end
  end

  // Read pipeline: stage 0 captures the array on the accepting edge.
  // Data and bank only advance with a valid entry, so the output stage holds
  // the last returned word. The error flag advances every cycle, so it can
  // only be high together with a valid response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < RD_LAT; k++) begin
        pv_q[k] <= 1'b0;
        pb_q[k] <= 1'b0;
        pd_q[k] <= '0;
        pe_q[k] <= 1'b0;
      end
    end else begin
      pv_q[0] <= rd_fire_s;
      pe_q[0] <= rd_fire_s & rd_perr_s;
      if (rd_fire_s) begin
        pb_q[0] <= req_bank_i;
        pd_q[0] <= rd_word_s[DATA_W-1:0];
      end
      for (int k = 1; k < RD_LAT; k++) begin
        pv_q[k] <= pv_q[k-1];
        pe_q[k] <= pe_q[k-1];
        if (pv_q[k-1]) begin
          pb_q[k] <= pb_q[k-1];
          pd_q[k] <= pd_q[k-1];
        end
      end
    end
  end

  assign req_ready_o = req_ready_q;
  assign init_busy_o = init_busy_q;
  assign rsp_valid_o = pv_q[RD_LAT-1];
  assign rsp_bank_o  = pb_q[RD_LAT-1];
  assign rsp_data_o  = pd_q[RD_LAT-1];
`ifdef PARITY_EN
  assign rsp_parity_err_o = pe_q[RD_LAT-1];
`endif

endmodule

// File: tb/tb_dmc_bank_responder.sv
module tb_dmc_bank_responder;

  localparam int LAT = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_bank = 1'b0;
  logic       req_we = 1'b0;
  logic [7:0] req_addr = 8'h00;
  logic [7:0] req_wdata = 8'h00;
  logic       err_inject = 1'b0;
  logic       req_ready;
  logic       rsp_valid;
  logic       rsp_bank;
  logic [7:0] rsp_data;
  logic       init_busy;
`ifdef PARITY_EN
  logic       rsp_parity_err;
`endif

  dmc_bank_responder #(
    .ADDR_W(8),
    .DATA_W(8),
    .RD_LAT(LAT)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .req_bank_i      (req_bank),
    .req_we_i        (req_we),
    .req_addr_i      (req_addr),
    .req_wdata_i     (req_wdata),
`ifdef PARITY_EN
    .err_inject_i    (err_inject),
    .rsp_parity_err_o(rsp_parity_err),
`endif
    .rsp_valid_o     (rsp_valid),
    .rsp_bank_o      (rsp_bank),
    .rsp_data_o      (rsp_data),
    .init_busy_o     (init_busy)
  );

  always #5 clk = ~clk;

  // Reference model: two plain arrays, a "corrupted" flag per word, and a queue of
  // expected responses stamped with the edge count at which they must show up.
  typedef struct {
    int         due;
    bit         bank;
    logic [7:0] data;
    bit         perr;
  } rsp_t;

  logic [7:0] m_mem [2][256];
  bit         m_bad [2][256];
  bit         m_serve = 1'b0;
  int         m_init = 0;
  int         ec = 0;
  logic [7:0] m_last = 8'h00;
  rsp_t       exp_q[$];

  int total = 0;
  int bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h (edge %0d)", tag, got, exp, ec);
    end
  endtask

  // One clock: update the model at the posedge, compare outputs at the negedge.
  task automatic tick();
    rsp_t e;
    @(posedge clk);
    ec++;
    if (rst) begin
      exp_q.delete();
      m_serve = 1'b0;
      m_init  = 0;
      m_last  = 8'h00;
      for (int b = 0; b < 2; b++) begin
        for (int a = 0; a < 256; a++) begin
          m_mem[b][a] = 8'h00;
          m_bad[b][a] = 1'b0;
        end
      end
    end else begin
      if (m_serve && req_valid) begin
        if (req_we) begin
          m_mem[req_bank][req_addr] = req_wdata;
`ifdef PARITY_EN
          m_bad[req_bank][req_addr] = err_inject;
`else
          m_bad[req_bank][req_addr] = 1'b0;
`endif
        end else begin
          e.due  = ec + LAT - 1;
          e.bank = req_bank;
          e.data = m_mem[req_bank][req_addr];
          e.perr = m_bad[req_bank][req_addr];
          exp_q.push_back(e);
        end
      end
      if (!m_serve) begin
        m_init++;
        if (m_init == 256) m_serve = 1'b1;
      end
    end
    @(negedge clk);
    check_eq("req_ready", {31'd0, req_ready}, {31'd0, m_serve});
    check_eq("init_busy", {31'd0, init_busy}, {31'd0, !m_serve});
    if (exp_q.size() > 0 && exp_q[0].due == ec) begin
      e = exp_q.pop_front();
      check_eq("rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check_eq("rsp_data", {24'd0, rsp_data}, {24'd0, e.data});
      check_eq("rsp_bank", {31'd0, rsp_bank}, {31'd0, e.bank});
`ifdef PARITY_EN
      check_eq("rsp_perr", {31'd0, rsp_parity_err}, {31'd0, e.perr});
`endif
      m_last = e.data;
    end else begin
      check_eq("rsp_idle", {31'd0, rsp_valid}, 32'd0);
      check_eq("rsp_hold", {24'd0, rsp_data}, {24'd0, m_last});
`ifdef PARITY_EN
      check_eq("perr_idle", {31'd0, rsp_parity_err}, 32'd0);
`endif
    end
  endtask

  task automatic req(input bit v, input bit we, input bit bank, input logic [7:0] addr,
                     input logic [7:0] data, input bit inj);
    req_valid  = v;
    req_we     = we;
    req_bank   = bank;
    req_addr   = addr;
    req_wdata  = data;
    err_inject = inj;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
  endtask

  // Release reset and wait (bounded) for ready; the clear phase must last 256 edges.
  task automatic do_init();
    int n;
    rst = 1'b0;
    req_valid = 1'b1;   // ignored while clearing
    req_we = 1'b1;
    n = 0;
    while (req_ready !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    req_valid = 1'b0;
    check_eq("init_len", n, 32'd256);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) tick();
    check_eq("rst_busy", {31'd0, init_busy}, 32'd1);
    check_eq("rst_ready", {31'd0, req_ready}, 32'd0);
    do_init();

    // Clear check: top address of bank A reads zero
    req(1'b1, 1'b0, 1'b0, 8'hFF, 8'h00, 1'b0);
    idle(LAT + 1);

    // Bank independence, all on consecutive edges
    req(1'b1, 1'b1, 1'b0, 8'h10, 8'hA5, 1'b0);
    req(1'b1, 1'b1, 1'b1, 8'h10, 8'h5A, 1'b0);
    req(1'b1, 1'b0, 1'b0, 8'h10, 8'h00, 1'b0);
    req(1'b1, 1'b0, 1'b1, 8'h10, 8'h00, 1'b0);
    idle(LAT + 1);

    // Write then read of the same word on the very next edge
    req(1'b1, 1'b1, 1'b1, 8'h33, 8'h7E, 1'b0);
    req(1'b1, 1'b0, 1'b1, 8'h33, 8'h00, 1'b0);
    idle(LAT + 1);

    // Streaming reads of preloaded words
    for (int i = 0; i < 4; i++) req(1'b1, 1'b1, 1'b0, 8'(i), 8'(8'h11 * (i + 1)), 1'b0);
    for (int i = 0; i < 4; i++) req(1'b1, 1'b0, 1'b0, 8'(i), 8'h00, 1'b0);
    idle(LAT + 1);

`ifdef PARITY_EN
    req(1'b1, 1'b1, 1'b1, 8'h22, 8'h3C, 1'b1);
    req(1'b1, 1'b0, 1'b1, 8'h22, 8'h00, 1'b1);
    idle(LAT + 1);
    req(1'b1, 1'b1, 1'b1, 8'h22, 8'h3C, 1'b0);
    req(1'b1, 1'b0, 1'b1, 8'h22, 8'h00, 1'b1);
    idle(LAT + 1);
`endif

    // Randomized mix, mostly on a small address window to get re-hits
    for (int i = 0; i < 600; i++) begin
      logic [7:0] a;
      a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
      req(($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), a, 8'($urandom), 1'($urandom));
    end
    idle(LAT + 1);

    // Reset while two reads are still in flight; nothing may come out afterwards
    req(1'b1, 1'b1, 1'b0, 8'h10, 8'hC3, 1'b0);
    req(1'b1, 1'b0, 1'b0, 8'h10, 8'h00, 1'b0);
    req(1'b1, 1'b0, 1'b1, 8'h10, 8'h00, 1'b0);
    req_valid = 1'b0;
    rst = 1'b1;
    tick();
    check_eq("rst_mid_valid", {31'd0, rsp_valid}, 32'd0);
    do_init();
    req(1'b1, 1'b0, 1'b0, 8'h10, 8'h00, 1'b0);
    req(1'b1, 1'b0, 1'b1, 8'h33, 8'h00, 1'b0);
    idle(LAT + 2);

    check_eq("drain", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
